// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store sequencer between the CPU and a word-wide
//               synchronous data RAM. Handles lw/lh/lhu/lb/lbu/sw/sh/sb.
//               Sub-word stores use read-modify-write. busy stalls the
//               CPU while an access is in flight.
//               Optional macro MAU_ALIGN_CHECK_EN: when defined, misaligned
//               halfword/word accesses are rejected with err. When undefined,
//               low address bits are ignored and every access reaches RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_we;
    logic [1:0]       op_size;
    logic             op_sign;
    logic [1:0]       op_lane;
    logic [31:0]      op_wdata;

    logic [1:0]       size_n;
    logic [1:0]       lane;
    logic             misaligned;

    // Pick the lane selected by the incoming request and classify alignment
    always_comb begin
        size_n     = (size == 2'b11) ? 2'b10 : size;
`ifdef MAU_ALIGN_CHECK_EN
        lane       = addr[1:0];
        misaligned = ((size_n == 2'b01) && addr[0]) ||
                     ((size_n == 2'b10) && (addr[1:0] != 2'b00));
`else
        // Alignment is forced: halfword keeps only addr[1], word ignores both
        misaligned = 1'b0;
        case (size_n)
            2'b00:   lane = addr[1:0];
            2'b01:   lane = {addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
`endif
    end

    // Extract the addressed lane of a RAM word and extend it to 32 bits
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] ln,
                                            input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{ln, 3'b000} +: 8];
        h = ln[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word with the store data
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] ln,
                                          input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (sz)
            2'b00: r[{ln, 3'b000} +: 8] = d[7:0];
            2'b01: begin
                if (ln[1]) r[31:16] = d[15:0];
                else       r[15:0]  = d[15:0];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // Transaction sequencer; all outputs are registered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_we     <= 1'b0;
            op_size   <= 2'b00;
            op_sign   <= 1'b0;
            op_lane   <= 2'b00;
            op_wdata  <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_we    <= we;
                        op_size  <= size_n;
                        op_sign  <= sign_ext;
                        op_lane  <= lane;
                        op_wdata <= wdata;
                        ram_addr <= {addr[ADDR_W-1:2], 2'b00};
                        busy     <= 1'b1;
                        if (misaligned) begin
                            // Rejected without touching RAM; a bad load clears rdata
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            if (!we) rdata <= '0;
                        end else if (we && (size_n == 2'b10)) begin
                            state     <= S_WRITE;
                            ram_we    <= 1'b1;
                            ram_wdata <= wdata;
                        end else begin
                            state <= S_READ;
                            cnt   <= CNT_W'(RD_LAT - 1);
                        end
                    end
                end
                S_READ: begin
                    if (cnt == '0) begin
                        if (op_we) begin
                            state     <= S_WRITE;
                            ram_we    <= 1'b1;
                            ram_wdata <= merge(ram_rdata, op_lane, op_size, op_wdata);
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            rdata <= extract(ram_rdata, op_lane, op_size, op_sign);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    ram_we <= 1'b0;
                    state  <= S_DONE;
                    done   <= 1'b1;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit. Two
//               instances (RD_LAT=1 and RD_LAT=3), each with its own RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req1, req3, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic [31:0] rdata1, ram_addr1, ram_wdata1, ram_rdata1;
    logic        busy1, done1, err1, ram_we1;
    logic [31:0] rdata3, ram_addr3, ram_wdata3, ram_rdata3;
    logic        busy3, done3, err3, ram_we3;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.RD_LAT(1), .ADDR_W(32)) u1 (
        .clock(clock), .reset_n(reset_n), .req(req1), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata1),
        .busy(busy1), .done(done1), .err(err1), .ram_addr(ram_addr1),
        .ram_we(ram_we1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    mem_access_unit #(.RD_LAT(3), .ADDR_W(32)) u3 (
        .clock(clock), .reset_n(reset_n), .req(req3), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata3),
        .busy(busy3), .done(done3), .err(err3), .ram_addr(ram_addr3),
        .ram_we(ram_we3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
    );

    // RAM models: data is valid only once the address has been stable long enough
    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic [31:0] last1 = '0, last3 = '0;
    int          age1 = 0, age3 = 0;

    always @(posedge clock) if (ram_we1) mem1[ram_addr1[7:2]] <= ram_wdata1;
    always @(posedge clock) if (ram_we3) mem3[ram_addr3[7:2]] <= ram_wdata3;

    always @(negedge clock) begin
        if (ram_addr1 != last1) begin age1 <= 0; last1 <= ram_addr1; end
        else if (age1 < 100) age1 <= age1 + 1;
        if (ram_addr3 != last3) begin age3 <= 0; last3 <= ram_addr3; end
        else if (age3 < 100) age3 <= age3 + 1;
    end

    assign ram_rdata1 = (age1 >= 0) ? mem1[ram_addr1[7:2]] : 32'hBAD0_BAD0;
    assign ram_rdata3 = (age3 >= 2) ? mem3[ram_addr3[7:2]] : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated transaction; returns latency (0 on timeout) and write activity
    task automatic txn(input bit inst3, input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int we_cyc, output int busy_cyc,
                       output logic [31:0] wa, output logic [31:0] wd, output logic e);
        @(negedge clock);
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        if (inst3) req3 = 1'b1; else req1 = 1'b1;
        lat = 0; we_cyc = 0; busy_cyc = 0; wa = '0; wd = '0; e = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (n == 1) begin
                // Scramble inputs: the unit must work from its latched copy
                req1 = 1'b0; req3 = 1'b0;
                we = ~w; size = ~sz; sign_ext = ~sx; addr = 32'hFFFF_FFFF; wdata = 32'h1234_5678;
            end
            if (inst3 ? ram_we3 : ram_we1) begin
                we_cyc++;
                wa = inst3 ? ram_addr3 : ram_addr1;
                wd = inst3 ? ram_wdata3 : ram_wdata1;
            end
            if (inst3 ? busy3 : busy1) busy_cyc++;
            if (inst3 ? done3 : done1) begin
                lat = n;
                e   = inst3 ? err3 : err1;
                break;
            end
        end
    endtask

    int          lat, wec, bc, d1, d2;
    logic [31:0] wa, wd, exp_word;
    logic        e;

    initial begin
        reset_n = 1'b0; req1 = 1'b0; req3 = 1'b0; we = 1'b0; size = 2'b00;
        sign_ext = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clock);
        check("rst_rdata", rdata1, 32'h0);
        check("rst_flags", {28'h0, busy1, done1, err1, ram_we1}, 32'h0);
        check("rst_ram_addr", ram_addr1, 32'h0);
        check("rst_ram_wdata", ram_wdata1, 32'h0);
        reset_n = 1'b1;

        // sw 0x10 DEADBEEF
        txn(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, lat, wec, bc, wa, wd, e);
        check("sw_lat", lat, 2);
        check("sw_we_cycles", wec, 1);
        check("sw_ram_addr", wa, 32'h10);
        check("sw_ram_wdata", wd, 32'hDEAD_BEEF);
        check("sw_busy", bc, 2);
        check("sw_err", e, 0);
        @(negedge clock);
        check("sw_mem", mem1[4], 32'hDEAD_BEEF);
        check("idle_busy", busy1, 0);

        // sb 0x11 0x55 -> read-modify-write
        txn(0, 1, 2'b00, 0, 32'h11, 32'hAAAA_AA55, lat, wec, bc, wa, wd, e);
        check("sb_lat", lat, 3);
        check("sb_busy", bc, 3);
        check("sb_ram_wdata", wd, 32'hDEAD_55EF);
        @(negedge clock);
        check("sb_mem", mem1[4], 32'hDEAD_55EF);

        // Loads from 0x8000_7F80
        txn(0, 1, 2'b10, 0, 32'h10, 32'h8000_7F80, lat, wec, bc, wa, wd, e);
        txn(0, 0, 2'b00, 1, 32'h10, 32'h0, lat, wec, bc, wa, wd, e);
        check("lb_lat", lat, 2);
        check("lb_no_write", wec, 0);
        check("lb_rdata", rdata1, 32'hFFFF_FF80);
        txn(0, 0, 2'b00, 0, 32'h10, 32'h0, lat, wec, bc, wa, wd, e);
        check("lbu_rdata", rdata1, 32'h0000_0080);
        txn(0, 0, 2'b01, 1, 32'h12, 32'h0, lat, wec, bc, wa, wd, e);
        check("lh_lat", lat, 2);
        check("lh_rdata", rdata1, 32'hFFFF_8000);
        txn(0, 0, 2'b01, 0, 32'h12, 32'h0, lat, wec, bc, wa, wd, e);
        check("lhu_rdata", rdata1, 32'h0000_8000);
        txn(0, 0, 2'b00, 1, 32'h11, 32'h0, lat, wec, bc, wa, wd, e);
        check("lb1_rdata", rdata1, 32'h0000_007F);
        txn(0, 0, 2'b00, 0, 32'h13, 32'h0, lat, wec, bc, wa, wd, e);
        check("lbu3_rdata", rdata1, 32'h0000_0080);

        // sh 0x12 upper half
        txn(0, 1, 2'b01, 0, 32'h12, 32'hFFFF_1234, lat, wec, bc, wa, wd, e);
        check("sh_lat", lat, 3);
        check("sh_ram_wdata", wd, 32'h1234_7F80);
        check("sh_keeps_rdata", rdata1, 32'h0000_0080);

        // lw 0x13 (misaligned when checking is enabled)
        txn(0, 0, 2'b10, 0, 32'h13, 32'h0, lat, wec, bc, wa, wd, e);
        check("lw13_no_write", wec, 0);
`ifdef MAU_ALIGN_CHECK_EN
        check("lw13_lat", lat, 1);
        check("lw13_err", e, 1);
        check("lw13_rdata", rdata1, 32'h0);
`else
        check("lw13_lat", lat, 2);
        check("lw13_err", e, 0);
        check("lw13_rdata", rdata1, 32'h1234_7F80);
`endif

        // sh 0x11 (misaligned when checking is enabled, else forced to 0x10)
        txn(0, 1, 2'b01, 0, 32'h11, 32'h0000_BEEF, lat, wec, bc, wa, wd, e);
        @(negedge clock);
`ifdef MAU_ALIGN_CHECK_EN
        check("sh11_lat", lat, 1);
        check("sh11_err", e, 1);
        check("sh11_we_cycles", wec, 0);
        check("sh11_keeps_rdata", rdata1, 32'h0);
        exp_word = 32'h1234_7F80;
`else
        check("sh11_lat", lat, 3);
        check("sh11_err", e, 0);
        check("sh11_we_cycles", wec, 1);
        check("sh11_keeps_rdata", rdata1, 32'h1234_7F80);
        exp_word = 32'h1234_BEEF;
`endif
        check("sh11_mem", mem1[4], exp_word);

        // Reserved size behaves as a word
        txn(0, 0, 2'b11, 1, 32'h10, 32'h0, lat, wec, bc, wa, wd, e);
        check("rsv_lat", lat, 2);
        check("rsv_rdata", rdata1, exp_word);

        // RD_LAT=3 instance
        txn(1, 1, 2'b10, 0, 32'h20, 32'hCAFE_F00D, lat, wec, bc, wa, wd, e);
        check("l3_sw_lat", lat, 2);
        txn(1, 0, 2'b00, 1, 32'h23, 32'h0, lat, wec, bc, wa, wd, e);
        check("l3_lb_lat", lat, 4);
        check("l3_lb_rdata", rdata3, 32'hFFFF_FFCA);
        txn(1, 1, 2'b00, 0, 32'h22, 32'h0000_0011, lat, wec, bc, wa, wd, e);
        check("l3_sb_lat", lat, 5);
        check("l3_sb_ram_wdata", wd, 32'hCA11_F00D);

        // Back-to-back lw 0x20 then sw 0x24 with req held high
        @(negedge clock);
        we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h20; wdata = '0; req3 = 1'b1;
        d1 = 0; d2 = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (n == 1) begin we = 1'b1; addr = 32'h24; wdata = 32'h0BAD_CAFE; end
            if (d1 != 0 && n == d1 + 1) check("b2b_idle_busy", busy3, 0);
            if (d1 != 0 && n == d1 + 2) req3 = 1'b0;
            if (done3 && d1 == 0) begin
                d1 = n;
                check("b2b_lw_rdata", rdata3, 32'hCA11_F00D);
            end else if (done3) begin
                d2 = n;
                break;
            end
        end
        req3 = 1'b0;
        check("b2b_first_done", d1, 4);
        check("b2b_second_done", d2, 7);
        @(negedge clock);
        check("b2b_mem", mem3[9], 32'h0BAD_CAFE);

        // Reset in the middle of a word write
        txn(0, 1, 2'b10, 0, 32'h30, 32'h0, lat, wec, bc, wa, wd, e);
        @(negedge clock);
        we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'h1111_2222; req1 = 1'b1;
        @(negedge clock);
        req1 = 1'b0;
        check("rw_we_before", ram_we1, 1);
        reset_n = 1'b0;
        #1;
        check("rw_we_after", ram_we1, 0);
        check("rw_busy_after", busy1, 0);
        @(negedge clock);
        check("rw_mem", mem1[12], 32'h0);
        check("rw_rdata", rdata1, 32'h0);
        reset_n = 1'b1;
        txn(0, 0, 2'b10, 0, 32'h10, 32'h0, lat, wec, bc, wa, wd, e);
        check("post_rst_lat", lat, 2);
        check("post_rst_rdata", rdata1, exp_word);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the CPU execute/control path and the word-wide synchronous data RAM block (14-bit word index taken from address bits [15:2]).
- Turns lw/lh/lhu/lb/lbu/sw/sh/sb requests into RAM word accesses.
- Sub-word stores use read-modify-write.
- Asserts busy so the single-cycle CPU stalls its PC while an access is in flight.

Parameters:
RD_LAT, 1, RAM read latency in clock cycles from stable ram_addr to valid ram_rdata (legal 1..4).
ADDR_W, 32, width of CPU and RAM byte addresses.

Ports:
clock  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
req  input  1  access request; sampled only in IDLE
we  input  1  1 = store, 0 = load
size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend
addr  input  ADDR_W  byte address from ALU
wdata  input  32  store data, right-aligned
rdata  output  32  load result, extended, registered
busy  output  1  high while a transaction is in progress
done  output  1  one-cycle pulse at transaction end
err  output  1  valid with done: misaligned access, no RAM write performed
ram_addr  output  ADDR_W  word-aligned byte address to RAM ({addr[ADDR_W-1:2],2'b00})
ram_we  output  1  RAM write enable
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - rdata, ram_addr, ram_wdata = 0.
  - busy, done, err, ram_we = 0.
  - ram_we drops immediately; no partial write completes after reset release.
- Accept: in IDLE with req=1, latch we/size/sign_ext/addr/wdata. Later changes to the inputs are ignored until done.
- busy is 1 in every non-IDLE state. busy is 0 in IDLE, including the DONE-exit cycle (see DONE state).
- Lanes (little-endian):
  - Byte k = bits [8k+7:8k], k = addr[1:0].
  - Halfword at bits [15:0] (addr[1]=0) or [31:16] (addr[1]=1).
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Go straight to DONE with err=1 and rdata=0.
  - No ram_we is issued.
- States:
  - IDLE: req=1 -> misaligned ? DONE : (store word ? WRITE : READ).
  - READ: ram_addr driven, down-counter loaded with RD_LAT-1. At count 0, sample ram_rdata on the rising edge.
    - Load -> DONE, rdata = extracted lane, extended.
    - Sub-word store -> WRITE, holding the merged word: old word with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - WRITE: exactly one cycle with ram_we=1, ram_addr stable, ram_wdata = full word (sw) or merged word. -> DONE.
  - DONE: done=1 for one cycle, err valid. -> IDLE. A new req in the following cycle is accepted normally (one idle cycle between transactions).
- Latency from accept edge to done-high cycle:
  - sw: 2 cycles.
  - Load: RD_LAT+1 cycles.
  - sb/sh: RD_LAT+2 cycles.
  - Misaligned: 1 cycle.
- ram_addr holds its value between transactions. ram_wdata is only meaningful while ram_we=1.
- rdata holds until the next completed load. Stores and err leave it unchanged, except a misaligned load, which clears it to 0.

Optional Feature:
MAU_ALIGN_CHECK_EN:
- Defined: misalignment detection and err as specified above.
- Undefined: err is tied to 0, and low address bits below the access size are ignored (forced aligned). Halfword uses addr[1]; word ignores addr[1:0]. Every request reaches the RAM.

Test Plan:
- Reset mid-WRITE of sw (assert reset_n=0 while ram_we=1) -> ram_we=0 the same cycle, state IDLE, RAM word unchanged if the write edge was not reached.
- sw addr=0x10 wdata=0xDEADBEEF, RD_LAT=1 -> ram_we high exactly one cycle with ram_addr=0x10, ram_wdata=0xDEADBEEF; done 2 cycles after accept.
- RAM[0x10]=0xDEADBEEF; sb addr=0x11 wdata=0x55 -> RMW writes 0xDEAD55EF; done at accept+3; busy high 3 cycles.
- RAM[0x10]=0x8000_7F80; lb addr=0x10 sign_ext=1 -> rdata=0xFFFFFF80; lbu -> 0x00000080; lh addr=0x12 sign_ext=1 -> 0xFFFF8000; done at accept+2.
- With MAU_ALIGN_CHECK_EN: lw addr=0x13 -> done+err at accept+1, rdata=0, no ram_we. Without it: same request reads word 0x10, err=0.
- RD_LAT=3, back-to-back lw 0x20 then sw 0x24 with req held high -> second accepted the cycle after done; done pulses at accept+4 and at accept2+2.
